// File: rtl/vit_sa_pkg.sv
// Shared types for the systolic-array tile scheduler.
// Holds the FSM state encoding and tile geometry constants.
package vit_sa_pkg;

  localparam int SA_TILE_DIM = 32;
  localparam int TILE_CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SA_ISSUE,
    ST_SA_WAIT,
    ST_STORE,
    ST_DONE
  } sa_sched_state_e;

endpackage

// File: rtl/tile_idx_counter.sv
// Nested m/n/k tile index counter (k innermost, m outermost).
// Limits are latched as count-1 so a count of 2^W-1 cannot overflow.
module tile_idx_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] m_cnt,
  input  logic [W-1:0] k_cnt,
  input  logic [W-1:0] n_cnt,
  input  logic         inc_k,
  input  logic         inc_mn,
  output logic [W-1:0] m_idx,
  output logic [W-1:0] k_idx,
  output logic [W-1:0] n_idx,
  output logic         m_last,
  output logic         k_last,
  output logic         n_last
);

  logic [W-1:0] m_max;
  logic [W-1:0] k_max;
  logic [W-1:0] n_max;

  assign m_last = (m_idx == m_max);
  assign k_last = (k_idx == k_max);
  assign n_last = (n_idx == n_max);

  // Latch limits on start; step k, or wrap k and step n then m.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_max <= '0;
      k_max <= '0;
      n_max <= '0;
      m_idx <= '0;
      k_idx <= '0;
      n_idx <= '0;
    end else if (load) begin
      m_max <= m_cnt - 1'b1;
      k_max <= k_cnt - 1'b1;
      n_max <= n_cnt - 1'b1;
      m_idx <= '0;
      k_idx <= '0;
      n_idx <= '0;
    end else if (inc_k) begin
      k_idx <= k_idx + 1'b1;
    end else if (inc_mn) begin
      k_idx <= '0;
      if (!n_last) begin
        n_idx <= n_idx + 1'b1;
      end else if (!m_last) begin
        n_idx <= '0;
        m_idx <= m_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sa_tile_scheduler.sv
// Tile-pass sequencer for the 32x32 systolic array.
// Walks m/n/k tiles: load -> SA pass -> (store on last k) with registered outputs.
module sa_tile_scheduler
  import vit_sa_pkg::*;
#(
  parameter int TILE_CNT_W = TILE_CNT_W_DEF,
  parameter int PROG_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [TILE_CNT_W-1:0] i_m_tiles,
  input  logic [TILE_CNT_W-1:0] i_k_tiles,
  input  logic [TILE_CNT_W-1:0] i_n_tiles,
  output logic                  o_load_req,
  output logic [TILE_CNT_W-1:0] o_m_idx,
  output logic [TILE_CNT_W-1:0] o_k_idx,
  output logic [TILE_CNT_W-1:0] o_n_idx,
  input  logic                  i_load_done,
  output logic                  o_sa_start,
  output logic                  o_acc_first,
  input  logic                  i_sa_done,
  output logic                  o_store_req,
  input  logic                  i_store_done,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [PROG_W-1:0]     o_tiles_stored
);

  sa_sched_state_e state, state_d;
  logic start_ok;
  logic err_d;
  logic inc_k;
  logic inc_mn;
  logic m_last;
  logic k_last;
  logic n_last;
  logic cnt_zero;

  assign cnt_zero = (i_m_tiles == '0) || (i_k_tiles == '0) ||
                    (i_n_tiles == '0);

  tile_idx_counter #(
    .W(TILE_CNT_W)
  ) u_idx (
    .clk   (i_clk),
    .rst   (i_rst),
    .load  (start_ok),
    .m_cnt (i_m_tiles),
    .k_cnt (i_k_tiles),
    .n_cnt (i_n_tiles),
    .inc_k (inc_k),
    .inc_mn(inc_mn),
    .m_idx (o_m_idx),
    .k_idx (o_k_idx),
    .n_idx (o_n_idx),
    .m_last(m_last),
    .k_last(k_last),
    .n_last(n_last)
  );

  // State register, registered outputs and stored-tile counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      o_load_req     <= 1'b0;
      o_sa_start     <= 1'b0;
      o_acc_first    <= 1'b0;
      o_store_req    <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_tiles_stored <= '0;
    end else begin
      state       <= state_d;
      o_load_req  <= (state_d == ST_LOAD);
      o_sa_start  <= (state_d == ST_SA_ISSUE);
      o_acc_first <= (state_d == ST_SA_ISSUE) && (o_k_idx == '0);
      o_store_req <= (state_d == ST_STORE);
      o_busy      <= (state_d != ST_IDLE);
      o_done      <= (state_d == ST_DONE);
      o_err       <= err_d;
      if (start_ok) begin
        o_tiles_stored <= '0;
      end else if (inc_mn) begin
        o_tiles_stored <= o_tiles_stored + 1'b1;
      end
    end
  end

  // Next state; only the done pulse owned by the current state acts.
  always_comb begin
    state_d  = state;
    start_ok = 1'b0;
    err_d    = 1'b0;
    inc_k    = 1'b0;
    inc_mn   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start) begin
          if (cnt_zero) begin
            err_d = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_d  = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (i_load_done) state_d = ST_SA_ISSUE;
      end
      ST_SA_ISSUE: begin
        state_d = ST_SA_WAIT;
      end
      ST_SA_WAIT: begin
        if (i_sa_done) begin
          if (!k_last) begin
            inc_k   = 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_STORE;
          end
        end
      end
      ST_STORE: begin
        if (i_store_done) begin
          inc_mn  = 1'b1;
          state_d = (n_last && m_last) ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed bench for sa_tile_scheduler.
// Table of tile-count runs plus hand-written error/stray/reset sequences.
module tb_sa_tile_scheduler;

  localparam int W  = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [W-1:0]  i_m_tiles;
  logic [W-1:0]  i_k_tiles;
  logic [W-1:0]  i_n_tiles;
  logic          o_load_req;
  logic [W-1:0]  o_m_idx;
  logic [W-1:0]  o_k_idx;
  logic [W-1:0]  o_n_idx;
  logic          i_load_done;
  logic          o_sa_start;
  logic          o_acc_first;
  logic          i_sa_done;
  logic          o_store_req;
  logic          i_store_done;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [PW-1:0] o_tiles_stored;

  always #5 clk = ~clk;

  sa_tile_scheduler #(
    .TILE_CNT_W(W),
    .PROG_W    (PW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_m_tiles     (i_m_tiles),
    .i_k_tiles     (i_k_tiles),
    .i_n_tiles     (i_n_tiles),
    .o_load_req    (o_load_req),
    .o_m_idx       (o_m_idx),
    .o_k_idx       (o_k_idx),
    .o_n_idx       (o_n_idx),
    .i_load_done   (i_load_done),
    .o_sa_start    (o_sa_start),
    .o_acc_first   (o_acc_first),
    .i_sa_done     (i_sa_done),
    .o_store_req   (o_store_req),
    .i_store_done  (i_store_done),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_tiles_stored(o_tiles_stored)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int m;
    int k;
    int n;
    int loads;
    int firsts;
    int stores;
    int dones;
    int stored;
    int abort_at;
    bit stray;
  } vec_t;

  function automatic logic [63:0] all_outs();
    return {o_load_req, o_m_idx, o_k_idx, o_n_idx, o_sa_start,
            o_acc_first, o_store_req, o_busy, o_done, o_err,
            o_tiles_stored};
  endfunction

  task automatic run_op(input vec_t v);
    int loads = 0;
    int starts = 0;
    int firsts = 0;
    int stores = 0;
    int dones = 0;
    int kind = 0;
    int cnt = 0;
    int p;
    bit finished = 0;
    bit aborted = 0;
    @(negedge clk);
    i_m_tiles = v.m[W-1:0];
    i_k_tiles = v.k[W-1:0];
    i_n_tiles = v.n[W-1:0];
    i_start   = 1'b1;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      @(negedge clk);
      i_start      = 1'b0;
      i_load_done  = 1'b0;
      i_sa_done    = 1'b0;
      i_store_done = 1'b0;
      chk("no_x", 64'($isunknown(all_outs())), 64'd0);
      if (o_busy)
        chk("idx_range", 64'(int'(o_m_idx) < v.m && int'(o_k_idx) < v.k &&
            int'(o_n_idx) < v.n), 64'd1);
      if (v.abort_at != 0 && starts == v.abort_at && kind == 2) begin
        i_rst   = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (o_done) begin
        dones++;
        chk("tiles_stored", 64'(o_tiles_stored), 64'(v.stored));
        finished = 1'b1;
        break;
      end
      if (kind != 0) begin
        cnt--;
        if (kind == 1 && v.stray && cnt == 2) begin
          i_start      = 1'b1;
          i_sa_done    = 1'b1;
          i_store_done = 1'b1;
        end
        if (kind == 1 && v.stray && cnt == 1)
          chk("stray_hold", 64'({o_load_req, o_sa_start, o_store_req,
              o_busy, o_k_idx}), 64'({4'b1001, 8'((loads - 1) % v.k)}));
        if (cnt == 0) begin
          case (kind)
            1: i_load_done  = 1'b1;
            2: i_sa_done    = 1'b1;
            default: i_store_done = 1'b1;
          endcase
          kind = 0;
        end
      end else if (o_load_req) begin
        p = loads;
        chk("load_idx", 64'({o_m_idx, o_n_idx, o_k_idx}),
            64'({8'(p / (v.k * v.n)), 8'((p / v.k) % v.n), 8'(p % v.k)}));
        loads++;
        kind = 1;
        cnt  = 3;
      end else if (o_sa_start) begin
        chk("acc_first", 64'(o_acc_first), 64'((starts % v.k) == 0));
        if (o_acc_first) firsts++;
        starts++;
        kind = 2;
        cnt  = 3;
      end else if (o_store_req) begin
        chk("store_idx", 64'({o_m_idx, o_n_idx}),
            64'({8'(stores / v.n), 8'(stores % v.n)}));
        stores++;
        kind = 3;
        cnt  = 3;
      end
    end
    if (!finished && !aborted) chk("timeout", 64'd1, 64'd0);
    chk("n_loads", 64'(loads), 64'(v.loads));
    chk("n_firsts", 64'(firsts), 64'(v.firsts));
    chk("n_stores", 64'(stores), 64'(v.stores));
    chk("n_dones", 64'(dones), 64'(v.dones));
    @(negedge clk);
    if (aborted) begin
      chk("abort_outs", all_outs(), 64'd0);
      i_rst = 1'b0;
    end else begin
      chk("post_done", 64'({o_done, o_busy, o_load_req}), 64'd0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    i_rst = 1'b1;
    i_start = 1'b0;
    i_load_done = 1'b0;
    i_sa_done = 1'b0;
    i_store_done = 1'b0;
    i_m_tiles = '0;
    i_k_tiles = '0;
    i_n_tiles = '0;

    vecs[0] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1'b0};
    vecs[1] = '{2, 3, 2, 12, 4, 4, 1, 4, 0, 1'b0};
    vecs[2] = '{1, 2, 3, 6, 3, 3, 1, 3, 0, 1'b0};
    vecs[3] = '{3, 1, 1, 3, 3, 3, 1, 3, 0, 1'b0};
    vecs[4] = '{1, 2, 2, 4, 2, 2, 1, 2, 0, 1'b1};
    vecs[5] = '{2, 3, 2, 5, 2, 1, 0, 0, 5, 1'b0};
    vecs[6] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_outs", all_outs(), 64'd0);
    i_rst = 1'b0;

    for (int i = 0; i < 7; i++) run_op(vecs[i]);

    @(negedge clk);
    i_m_tiles = 8'd2;
    i_k_tiles = 8'd0;
    i_n_tiles = 8'd2;
    i_start   = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("err_pulse", 64'({o_err, o_busy, o_load_req}), 64'b100);
    @(negedge clk);
    chk("err_clear", 64'({o_err, o_busy, o_load_req}), 64'd0);
    repeat (2) @(negedge clk);
    chk("err_idle", 64'({o_busy, o_load_req, o_sa_start}), 64'd0);

    run_op('{255, 255, 255, 1000, 4, 3, 0, 0, 1000, 1'b0});
    run_op('{1, 1, 1, 1, 1, 1, 1, 1, 0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
